mem_stage: RTL

Memory-access stage of the five-stage RISC-V core, sitting between the EX/MEM pipeline register and the MEM/WB register, which consumes its `rd_*_o` outputs. It executes LB/LH/LW/LBU/LHU/SB/SH/SW over a byte-wide memory-controller port, one byte per acknowledged transfer. While a transfer is in progress it raises `stall_req_o` to the stall controller. Non-memory instructions pass straight through.

---
 rtl/mem_stage.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage RV32 core. Each load/store is
// split into byte transfers on an 8-bit memory port, and the pipeline is stalled until it finishes.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_write_i,
    input  logic [31:0] rd_data_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] store_data_i,
    output logic [4:0]  rd_addr_o,
    output logic        rd_write_o,
    output logic [31:0] rd_data_o,
    output logic        stall_req_o,
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] sdata_q, sdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [1:0]  last_idx_q, last_idx_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  buf_q [4];
    logic [7:0]  buf_d [4];
    logic        mem_req_q, mem_req_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;

    logic        mem_op;
    logic        start;
    logic        capture;
    logic        last_ack;
    logic [1:0]  next_idx;
    logic [1:0]  op_last_idx;
    logic [7:0]  sdata_byte [4];
    logic [31:0] load_word;
    logic [31:0] load_ext;

    assign mem_op   = mem_read_i | mem_write_i;
    assign start    = (state_q == IDLE) && mem_op;
    assign capture  = (state_q == XFER) && mem_ack_i && !is_store_q;
    assign last_ack = (state_q == XFER) && mem_ack_i && (idx_q == last_idx_q);
    assign next_idx = idx_q + 2'd1;

    // The byte count is kept as the index of the final byte (0, 1 or 3).
    always_comb begin
        case (mem_funct3_i[1:0])
            2'b00:   op_last_idx = 2'd0;
            2'b01:   op_last_idx = 2'd1;
            default: op_last_idx = 2'd3;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign sdata_byte[gi]        = sdata_q[8*gi +: 8];
            assign load_word[8*gi +: 8]  = buf_q[gi];
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            buf_d[i] = buf_q[i];
            if (start) begin
                buf_d[i] = 8'h00;
            end else if (capture && (idx_q == 2'(i))) begin
                buf_d[i] = mem_rdata_i;
            end
        end
    end

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
            3'b100:  load_ext = {24'h000000, load_word[7:0]};
            3'b101:  load_ext = {16'h0000, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        sdata_d     = sdata_q;
        funct3_d    = funct3_q;
        is_store_d  = is_store_q;
        last_idx_d  = last_idx_q;
        idx_d       = idx_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d     = XFER;
                    base_d      = mem_addr_i;
                    sdata_d     = store_data_i;
                    funct3_d    = mem_funct3_i;
                    // A load takes priority when both read and write are flagged.
                    is_store_d  = mem_write_i & ~mem_read_i;
                    last_idx_d  = op_last_idx;
                    idx_d       = 2'd0;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = mem_write_i & ~mem_read_i;
                    mem_addr_d  = mem_addr_i;
                    mem_wdata_d = store_data_i[7:0];
                end
            end
            XFER: begin
                if (last_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_wr_d  = 1'b0;
                end else if (mem_ack_i) begin
                    idx_d       = next_idx;
                    mem_addr_d  = base_q + {30'd0, next_idx};
                    mem_wdata_d = sdata_byte[next_idx];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_wr_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= 32'd0;
            sdata_q     <= 32'd0;
            funct3_q    <= 3'd0;
            is_store_q  <= 1'b0;
            last_idx_q  <= 2'd0;
            idx_q       <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            sdata_q     <= sdata_d;
            funct3_q    <= funct3_d;
            is_store_q  <= is_store_d;
            last_idx_q  <= last_idx_d;
            idx_q       <= idx_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign rd_addr_o   = rd_addr_i;
    assign rd_write_o  = rd_write_i;
    assign rd_data_o   = ((state_q == DONE) && !is_store_q) ? load_ext : rd_data_i;
    assign stall_req_o = rst & (start | (state_q == XFER));

    assign mem_req_o   = mem_req_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
